// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered datapath bus mux with hold-on-idle, source tag and conflict monitor.
// Latency: 1 cycle from enables/data to BusOut/SrcId/BusValid/Conflict/ConflictCnt.
// Backpressure: none; a source is sampled every cycle and the bus holds when nothing drives it.
//
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   Rflat                 NREG packed general registers, R[i] = Rflat[i*DW +: DW]
//   Gin, Din              G (ALU result) register and external data
//   SRout, SGout, SDout   output enables (priority G > Din > lowest R)
//   ConflictClr           clears the sticky conflict flag and counter
//   BusOut, BusValid      registered bus value and "loaded last cycle" strobe
//   SrcId                 source of BusOut: i = R[i], NREG = Din, NREG+1 = G
//   Conflict, ConflictCnt sticky multi-driver flag and saturating conflict-cycle count
module bus_mux_reg #(
  parameter int DW   = 9,
  parameter int NREG = 8,
  parameter int CW   = 8,
  parameter int SW   = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NREG*DW-1:0]   Rflat,
  input  logic [DW-1:0]        Gin,
  input  logic [DW-1:0]        Din,
  input  logic [NREG-1:0]      SRout,
  input  logic                 SGout,
  input  logic                 SDout,
  input  logic                 ConflictClr,
  output logic [DW-1:0]        BusOut,
  output logic                 BusValid,
  output logic [SW-1:0]        SrcId,
  output logic                 Conflict,
  output logic [CW-1:0]        ConflictCnt
);

  // Enable count must hold up to NREG+2 drivers.
  localparam int NW = $clog2(NREG + 3);

  if ((1 << SW) < NREG + 2) begin : g_bad_sw
    $error("bus_mux_reg: SW too narrow to encode NREG+2 sources");
  end

  logic [NW-1:0] n_en;
  logic [DW-1:0] sel_dat;
  logic [SW-1:0] sel_id;
  logic          any_en;
  logic          multi_en;
  logic [CW-1:0] cnt_inc;

  // Walking the registers downward leaves the lowest set bit as the winner;
  // Din and then G override afterwards, giving G > Din > lowest R.
  always_comb begin
    n_en    = NW'(SGout) + NW'(SDout);
    sel_dat = '0;
    sel_id  = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      n_en = n_en + NW'(SRout[i]);
      if (SRout[i]) begin
        sel_dat = Rflat[i*DW +: DW];
        sel_id  = SW'(i);
      end
    end
    if (SDout) begin
      sel_dat = Din;
      sel_id  = SW'(NREG);
    end
    if (SGout) begin
      sel_dat = Gin;
      sel_id  = SW'(NREG + 1);
    end
  end

  assign any_en   = (n_en != '0);
  assign multi_en = (n_en > NW'(1));
  // Saturate rather than wrap so a long-running fault never reads as "few conflicts".
  assign cnt_inc  = (ConflictCnt == {CW{1'b1}}) ? ConflictCnt : ConflictCnt + CW'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      BusOut      <= '0;
      BusValid    <= 1'b0;
      SrcId       <= '0;
      Conflict    <= 1'b0;
      ConflictCnt <= '0;
    end else begin
      // Idle cycles keep the last bus value and tag; only the strobe drops.
      if (any_en) begin
        BusOut   <= sel_dat;
        SrcId    <= sel_id;
        BusValid <= 1'b1;
      end else begin
        BusValid <= 1'b0;
      end

      // A conflict coinciding with a clear restarts the count at this event
      // instead of dropping it.
      if (multi_en) begin
        Conflict    <= 1'b1;
        ConflictCnt <= ConflictClr ? CW'(1) : cnt_inc;
      end else if (ConflictClr) begin
        Conflict    <= 1'b0;
        ConflictCnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_mux_reg.sv
module tb_bus_mux_reg;

  localparam int DW = 9, NREG = 8, CW = 8, SW = 4;
  localparam int DW2 = 16, NREG2 = 4, SW2 = 3;

  typedef struct packed {
    logic [15:0] bus;
    logic        valid;
    logic [3:0]  id;
    logic        conf;
    logic [7:0]  cnt;
  } obs_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREG*DW-1:0]   rflat;
  logic [DW-1:0]        gin, din;
  logic [NREG-1:0]      srout;
  logic                 sgout, sdout, cclr;
  logic [DW-1:0]        bus_out;
  logic                 bus_valid;
  logic [SW-1:0]        src_id;
  logic                 conflict;
  logic [CW-1:0]        conflict_cnt;

  logic [NREG2*DW2-1:0] p_rflat;
  logic [DW2-1:0]       p_gin, p_din;
  logic [NREG2-1:0]     p_srout;
  logic                 p_sgout, p_sdout, p_cclr;
  logic [DW2-1:0]       p_bus;
  logic                 p_valid;
  logic [SW2-1:0]       p_id;
  logic                 p_conf;
  logic [CW-1:0]        p_cnt;

  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];
  obs_t sb2[$];
  obs_t m, m2, e, g;
  bit   chk2 = 0;

  always #5 clk = ~clk;

  bus_mux_reg #(.DW(DW), .NREG(NREG), .CW(CW), .SW(SW)) dut (
    .Clock(clk), .Reset(rst), .Rflat(rflat), .Gin(gin), .Din(din),
    .SRout(srout), .SGout(sgout), .SDout(sdout), .ConflictClr(cclr),
    .BusOut(bus_out), .BusValid(bus_valid), .SrcId(src_id),
    .Conflict(conflict), .ConflictCnt(conflict_cnt)
  );

  bus_mux_reg #(.DW(DW2), .NREG(NREG2), .CW(CW), .SW(SW2)) dut2 (
    .Clock(clk), .Reset(rst), .Rflat(p_rflat), .Gin(p_gin), .Din(p_din),
    .SRout(p_srout), .SGout(p_sgout), .SDout(p_sdout), .ConflictClr(p_cclr),
    .BusOut(p_bus), .BusValid(p_valid), .SrcId(p_id),
    .Conflict(p_conf), .ConflictCnt(p_cnt)
  );

  function automatic obs_t obs1();
    return {7'd0, bus_out, bus_valid, src_id, conflict, conflict_cnt};
  endfunction

  function automatic obs_t obs2();
    return {p_bus, p_valid, 1'b0, p_id, p_conf, p_cnt};
  endfunction

  // Reference model: next observable state from the current one and this cycle's inputs.
  function automatic obs_t model(obs_t st, logic r, logic clr, logic sg, logic sd,
                                 logic [7:0] sr, int nreg, int dw, logic [127:0] rf,
                                 logic [15:0] gv, logic [15:0] dv);
    obs_t   nx;
    int     n;
    logic [127:0] mask;
    nx   = st;
    mask = (128'(1) << dw) - 128'(1);
    n    = int'(sg) + int'(sd) + $countones(sr);
    if (r) return '0;
    if (n == 0) nx.valid = 1'b0;
    else begin
      nx.valid = 1'b1;
      if (sg) begin
        nx.bus = gv; nx.id = 4'(nreg + 1);
      end else if (sd) begin
        nx.bus = dv; nx.id = 4'(nreg);
      end else begin
        for (int i = 0; i < nreg; i++) begin
          if (sr[i]) begin
            nx.bus = 16'((rf >> (i * dw)) & mask);
            nx.id  = 4'(i);
            break;
          end
        end
      end
    end
    if (n >= 2) begin
      nx.conf = 1'b1;
      if (clr) nx.cnt = 8'd1;
      else if (st.cnt != 8'hFF) nx.cnt = st.cnt + 8'd1;
    end else if (clr) begin
      nx.conf = 1'b0;
      nx.cnt  = 8'd0;
    end
    return nx;
  endfunction

  // One clock: predict, push expectations, advance to just after the edge.
  task automatic cycle();
    m  = model(m, rst, cclr, sgout, sdout, 8'(srout), NREG, DW, 128'(rflat),
               16'(gin), 16'(din));
    m2 = model(m2, rst, p_cclr, p_sgout, p_sdout, 8'(p_srout), NREG2, DW2,
               128'(p_rflat), p_gin, p_din);
    sb.push_back(m);
    if (chk2) sb2.push_back(m2);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    srout = '0; sgout = 0; sdout = 0; cclr = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    rflat = '0; gin = '0; din = '0;
    cycle();
    e = sb.pop_front(); g = obs1(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_sb got %h exp %h", g, e); end
    checks++;
    if (g !== obs_t'(0)) begin errors++; $display("FAIL reset_zero got %h exp 0", g); end
    rst = 0;
  endtask

  task automatic test_single_reg();
    rflat = 72'h0;
    rflat[2*DW +: DW] = 9'h1A5;
    rflat[0 +: DW]    = 9'h0C3;
    srout = 8'h04;
    cycle();
    e = sb.pop_front(); g = obs1(); checks++;
    if (g !== e) begin errors++; $display("FAIL single_sb got %h exp %h", g, e); end
    checks++;
    if (bus_out !== 9'h1A5 || src_id !== 4'd2 || bus_valid !== 1'b1 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL single_r2 bus=%h id=%0d vld=%b conf=%b exp 1a5/2/1/0",
               bus_out, src_id, bus_valid, conflict);
    end
  endtask

  task automatic test_conflict();
    sgout = 1; sdout = 1; srout = 8'h80; gin = 9'h0F0; din = 9'h111;
    cycle();
    e = sb.pop_front(); g = obs1(); checks++;
    if (g !== e) begin errors++; $display("FAIL conflict_sb got %h exp %h", g, e); end
    checks++;
    if (bus_out !== 9'h0F0 || src_id !== 4'd9 || conflict !== 1'b1 || conflict_cnt !== 8'd1) begin
      errors++;
      $display("FAIL conflict_g bus=%h id=%0d conf=%b cnt=%0d exp 0f0/9/1/1",
               bus_out, src_id, conflict, conflict_cnt);
    end
    sgout = 0; srout = 8'h00;
    cycle();
    e = sb.pop_front(); g = obs1(); checks++;
    if (g !== e) begin errors++; $display("FAIL conflict_din_sb got %h exp %h", g, e); end
    checks++;
    if (bus_out !== 9'h111 || src_id !== 4'd8 || conflict !== 1'b1 || conflict_cnt !== 8'd1) begin
      errors++;
      $display("FAIL conflict_din bus=%h id=%0d conf=%b cnt=%0d exp 111/8/1/1",
               bus_out, src_id, conflict, conflict_cnt);
    end
    sdout = 0;
  endtask

  task automatic test_hold();
    rflat[5*DW +: DW] = 9'h033;
    srout = 8'h20;
    cycle();
    e = sb.pop_front(); g = obs1(); checks++;
    if (g !== e) begin errors++; $display("FAIL hold_load got %h exp %h", g, e); end
    srout = 8'h00;
    rflat[0 +: DW] = 9'h1FF;
    for (int k = 0; k < 3; k++) begin
      cycle();
      e = sb.pop_front(); g = obs1(); checks++;
      if (g !== e) begin errors++; $display("FAIL hold_sb[%0d] got %h exp %h", k, g, e); end
      checks++;
      if (bus_out !== 9'h033 || src_id !== 4'd5 || bus_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] bus=%h id=%0d vld=%b exp 033/5/0", k, bus_out, src_id, bus_valid);
      end
    end
  endtask

  task automatic test_saturate();
    rflat[1*DW +: DW] = 9'h0AB;
    rflat[4*DW +: DW] = 9'h154;
    srout = 8'h12;
    for (int k = 0; k < 300; k++) begin
      cycle();
      e = sb.pop_front(); g = obs1(); checks++;
      if (g !== e) begin errors++; $display("FAIL sat_sb[%0d] got %h exp %h", k, g, e); end
    end
    checks++;
    if (conflict_cnt !== 8'd255 || bus_out !== 9'h0AB || src_id !== 4'd1) begin
      errors++;
      $display("FAIL sat_hold cnt=%0d bus=%h id=%0d exp 255/0ab/1", conflict_cnt, bus_out, src_id);
    end
    cclr = 1; srout = 8'h02;
    cycle();
    e = sb.pop_front(); g = obs1(); checks++;
    if (g !== e) begin errors++; $display("FAIL clr_sb got %h exp %h", g, e); end
    checks++;
    if (conflict !== 1'b0 || conflict_cnt !== 8'd0) begin
      errors++; $display("FAIL clr conf=%b cnt=%0d exp 0/0", conflict, conflict_cnt);
    end
    srout = 8'h03;
    cycle();
    e = sb.pop_front(); g = obs1(); checks++;
    if (g !== e) begin errors++; $display("FAIL clr_conf_sb got %h exp %h", g, e); end
    checks++;
    if (conflict !== 1'b1 || conflict_cnt !== 8'd1) begin
      errors++; $display("FAIL clr_conf conf=%b cnt=%0d exp 1/1", conflict, conflict_cnt);
    end
    cclr = 0; srout = 8'h00;
  endtask

  task automatic test_reset_mid();
    rst = 1; sgout = 1; cclr = 1; gin = 9'h155;
    cycle();
    e = sb.pop_front(); g = obs1(); checks++;
    if (g !== e) begin errors++; $display("FAIL rstmid_sb got %h exp %h", g, e); end
    checks++;
    if (g !== obs_t'(0)) begin errors++; $display("FAIL rstmid_zero got %h exp 0", g); end
    rst = 0; cclr = 0;
    cycle();
    e = sb.pop_front(); g = obs1(); checks++;
    if (g !== e) begin errors++; $display("FAIL resume_sb got %h exp %h", g, e); end
    checks++;
    if (bus_out !== 9'h155 || src_id !== 4'd9 || bus_valid !== 1'b1) begin
      errors++;
      $display("FAIL resume bus=%h id=%0d vld=%b exp 155/9/1", bus_out, src_id, bus_valid);
    end
    sgout = 0;
  endtask

  task automatic test_param_sweep();
    logic [15:0] exp_d [6];
    exp_d = '{16'hA55A, 16'hBEEF, 16'hC0DE, 16'hD00D, 16'h1234, 16'h8001};
    p_rflat = {16'hD00D, 16'hC0DE, 16'hBEEF, 16'hA55A};
    p_din = 16'h1234; p_gin = 16'h8001;
    chk2 = 1;
    for (int i = 0; i < 6; i++) begin
      p_srout = (i < 4) ? 4'(1 << i) : 4'd0;
      p_sdout = (i == 4);
      p_sgout = (i == 5);
      cycle();
      e = sb.pop_front(); g = obs1(); checks++;
      if (g !== e) begin errors++; $display("FAIL sweep_main_sb[%0d] got %h exp %h", i, g, e); end
      e = sb2.pop_front(); g = obs2(); checks++;
      if (g !== e) begin errors++; $display("FAIL sweep_sb[%0d] got %h exp %h", i, g, e); end
      checks++;
      if (p_id !== 3'(i) || p_bus !== exp_d[i] || p_valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep[%0d] id=%0d bus=%h vld=%b exp %0d/%h/1", i, p_id, p_bus, p_valid, i, exp_d[i]);
      end
    end
    p_srout = '0; p_sdout = 0; p_sgout = 0;
    chk2 = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      rflat = 72'({$urandom(), $urandom(), $urandom()});
      gin   = 9'($urandom());
      din   = 9'($urandom());
      srout = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7))
                                          : (8'($urandom()) & 8'($urandom()));
      sgout = ($urandom_range(0, 4) == 0);
      sdout = ($urandom_range(0, 4) == 0);
      cclr  = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 31) == 0);
      cycle();
      e = sb.pop_front(); g = obs1(); checks++;
      if (g !== e) begin errors++; $display("FAIL random_sb[%0d] got %h exp %h", k, g, e); end
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    m = '0; m2 = '0;
    p_rflat = '0; p_gin = '0; p_din = '0; p_srout = '0;
    p_sgout = 0; p_sdout = 0; p_cclr = 0;
    #1;
    test_reset();
    test_single_reg();
    test_conflict();
    test_hold();
    test_saturate();
    test_reset_mid();
    test_param_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
